// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the icache miss path
// and the dcache miss/writeback path. One line transfer at a time; ties
// alternate between the two sides so neither can starve the other.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // Handshake: a requester raises read/write with a stable address (and
    // data) and holds it until its own resp pulses for one cycle; it drops
    // the request on that edge. Memory sees a held strobe until pmem_resp.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;   // 0 = icache served last, 1 = dcache
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_q;         // registered pmem read strobe
    logic              wr_q;         // registered pmem write strobe (latched d_write)

    logic d_req;
    logic grant_d;
    logic grant_i;

    // Arbitration decision: a tie goes to the side that was not served last.
    always_comb begin
        d_req   = d_read | d_write;
        grant_d = d_req & (~i_read | ~last_grant);
        grant_i = i_read & ~grant_d;
    end

    // Transfer FSM: grant in IDLE, hold strobes until memory completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        last_grant <= 1'b1;
                        addr_q     <= d_address;
                        wdata_q    <= d_wdata;
                        // Write wins when both d_read and d_write are set.
                        wr_q       <= d_write;
                        rd_q       <= ~d_write;
                    end else if (grant_i) begin
                        state      <= SERVE_I;
                        last_grant <= 1'b0;
                        addr_q     <= i_address;
                        rd_q       <= 1'b1;
                        wr_q       <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side outputs come straight from registers; reset forces strobes off
    // in the very cycle it is asserted, including mid-transfer.
    always_comb begin
        pmem_read    = rd_q & ~reset;
        pmem_write   = wr_q & ~reset;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
    end

    // Completion is forwarded in the same cycle memory reports it; read data
    // is a pass-through, valid only while the matching resp is high.
    always_comb begin
        i_rdata = pmem_rdata;
        d_rdata = pmem_rdata;
        i_resp  = (state == SERVE_I) & pmem_resp & ~reset;
        d_resp  = (state == SERVE_D) & pmem_resp & ~reset;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all cycles checked against a transaction-level scoreboard.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic              side;   // 0 = icache, 1 = dcache
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } xfer_t;

    xfer_t exp_q[$];          // granted transfers, front = the one on the bus
    logic  model_last;        // side most recently granted
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Transaction-level reference: while a transfer is outstanding the bus
    // must show it; otherwise nothing is driven and held requests are granted
    // by the alternating-tie rule.
    task automatic model_cycle();
        xfer_t f;
        logic  want_i;
        logic  want_d;
        logic  side;
        if (reset) begin
            check("rst_pmem_read", pmem_read, 0);
            check("rst_pmem_write", pmem_write, 0);
            check("rst_i_resp", i_resp, 0);
            check("rst_d_resp", d_resp, 0);
            exp_q.delete();
            model_last = 1'b0;
            return;
        end
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("pmem_read", pmem_read, !f.wr);
            check("pmem_write", pmem_write, f.wr);
            check("pmem_address", pmem_address, f.addr);
            if (f.wr) check("pmem_wdata", pmem_wdata, f.wdata);
            check("i_resp", i_resp, (f.side == 1'b0) && pmem_resp);
            check("d_resp", d_resp, (f.side == 1'b1) && pmem_resp);
            if (pmem_resp) begin
                if (f.side == 1'b0)      check("i_rdata", i_rdata, pmem_rdata);
                else if (!f.wr)          check("d_rdata", d_rdata, pmem_rdata);
                exp_q.pop_front();
            end
        end else begin
            check("idle_pmem_read", pmem_read, 0);
            check("idle_pmem_write", pmem_write, 0);
            check("idle_i_resp", i_resp, 0);
            check("idle_d_resp", d_resp, 0);
            want_i = i_read;
            want_d = d_read | d_write;
            if (want_i || want_d) begin
                if (want_i && want_d) side = ~model_last;
                else                  side = want_d;
                if (side) exp_q.push_back('{1'b1, d_write, d_address, d_wdata});
                else      exp_q.push_back('{1'b0, 1'b0, i_address, '0});
                model_last = side;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are driven right after a falling edge; one call closes the cycle.
    task automatic cyc();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [LINE_W-1:0] wd;
    logic [ADDR_W-1:0] exp_addr;
    int                ni, nd, lat;
    logic              exp_d;
    logic              i_seen, d_seen;

    initial begin
        model_last = 1'b0;
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Reset state with no traffic.
        #1;
        check("reset_pmem_read", pmem_read, 0);
        check("reset_pmem_write", pmem_write, 0);
        cyc();

        // Single icache read: request in cycle 0, strobe from cycle 1, resp in cycle 4.
        i_read = 1'b1;
        i_address = 16'h1230;
        #1 check("t1_arb_no_strobe", pmem_read, 0);
        cyc();
        for (int c = 1; c <= 3; c++) begin
            #1;
            check("t1_pmem_read", pmem_read, 1);
            check("t1_pmem_address", pmem_address, 16'h1230);
            check("t1_no_resp_yet", i_resp, 0);
            cyc();
        end
        pmem_resp = 1'b1;
        pmem_rdata = {16{8'hA5}};
        #1;
        check("t1_i_resp", i_resp, 1);
        check("t1_i_rdata", i_rdata, {16{8'hA5}});
        cyc();
        pmem_resp = 1'b0;
        i_read = 1'b0;
        #1;
        check("t1_resp_drop", i_resp, 0);
        check("t1_read_drop", pmem_read, 0);
        cyc();

        // dcache writeback; wdata changes after the grant must not leak through.
        wd = {2{64'h0123_4567_89AB_CDEF}};
        d_write = 1'b1;
        d_address = 16'h4000;
        d_wdata = wd;
        cyc();
        d_wdata = ~wd;
        #1;
        check("t2_pmem_write", pmem_write, 1);
        check("t2_pmem_read", pmem_read, 0);
        check("t2_pmem_wdata", pmem_wdata, wd);
        check("t2_pmem_address", pmem_address, 16'h4000);
        cyc();
        pmem_resp = 1'b1;
        #1 check("t2_d_resp", d_resp, 1);
        cyc();
        pmem_resp = 1'b0;
        d_write = 1'b0;
        d_wdata = '0;
        cyc();

        // Ties after reset: both sides keep requesting; dcache first, then alternate.
        do_reset();
        ni = 0;
        nd = 0;
        i_read = 1'b1;
        d_read = 1'b1;
        i_address = 16'h1000;
        d_address = 16'h2000;
        cyc();
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            exp_addr = exp_d ? 16'h2000 + ADDR_W'(nd * 16) : 16'h1000 + ADDR_W'(ni * 16);
            #1;
            check("tie_pmem_address", pmem_address, exp_addr);
            check("tie_pmem_read", pmem_read, 1);
            cyc();
            pmem_resp = 1'b1;
            pmem_rdata = {4{$urandom}};
            #1;
            check("tie_i_resp", i_resp, !exp_d);
            check("tie_d_resp", d_resp, exp_d);
            cyc();
            pmem_resp = 1'b0;
            if (exp_d) nd++; else ni++;
            i_address = 16'h1000 + ADDR_W'(ni * 16);
            d_address = 16'h2000 + ADDR_W'(nd * 16);
            if (k == 3) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            #1 check("tie_idle_gap", pmem_read, 0);
            cyc();
        end
        cyc();

        // Reset in the middle of a dcache read, then a stray memory response.
        d_read = 1'b1;
        d_address = 16'h3000;
        cyc();
        #1 check("t5_serving", pmem_read, 1);
        cyc();
        reset = 1'b1;
        d_read = 1'b0;
        #1 check("t5_reset_strobe", pmem_read, 0);
        cyc();
        reset = 1'b0;
        #1;
        check("t5_after_read", pmem_read, 0);
        check("t5_after_write", pmem_write, 0);
        cyc();
        pmem_resp = 1'b1;
        #1;
        check("t5_stray_i_resp", i_resp, 0);
        check("t5_stray_d_resp", d_resp, 0);
        cyc();
        pmem_resp = 1'b0;

        // Stray response while idle leaves the arbiter idle.
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        #1 check("t6_still_idle", pmem_read, 0);
        cyc();

        // Randomized traffic with a random-latency memory and stray responses.
        i_seen = 1'b0;
        d_seen = 1'b0;
        lat = $urandom_range(0, 3);
        for (int n = 0; n < 3000; n++) begin
            if (i_seen) i_read = 1'b0;
            if (d_seen) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end
            if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_address = ADDR_W'($urandom) & 16'hFFF0;
            end
            if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) d_write = 1'b1;
                else                           d_read = 1'b1;
                d_address = ADDR_W'($urandom) & 16'hFFF0;
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (exp_q.size() != 0 && exp_q[0].side) begin
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (pmem_read || pmem_write) begin
                if (lat == 0) begin
                    pmem_resp = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    pmem_resp = 1'b0;
                    lat--;
                end
            end else begin
                pmem_resp = ($urandom_range(0, 7) == 0);
            end
            #1;
            model_cycle();
            i_seen = i_resp;
            d_seen = d_resp;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
